// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO push arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic int ID_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Round-robin picker: rotate requests so last_id+1 sits at bit 0,
// priority-encode the lowest set bit, then rotate the index back.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_id,
    output logic          found,
    output logic [IW-1:0] win
);

    logic [IW-1:0] start;
    logic [N-1:0]  rot;
    logic [IW-1:0] off;
    logic [IW:0]   sum;

    // N need not be a power of two, so the wraps are explicit compares.
    assign start = (last_id == IW'(N - 1)) ? '0 : last_id + 1'b1;
    assign rot   = N'({req, req} >> start);
    assign found = |req;

    always_comb begin
        off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) off = IW'(k);
        end
    end

    assign sum = {1'b0, start} + {1'b0, off};
    assign win = (sum >= (IW + 1)'(N)) ? IW'(sum - (IW + 1)'(N)) : sum[IW-1:0];

endmodule

// File: rtl/fifo_push_arbiter.sv
// Packet-locked round-robin arbiter sharing one FIFO push port among
// REQ_COUNT requesters; runs entirely in the FIFO write-clock domain.
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int REQ_COUNT  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8
) (
    input  logic                            MCLK,
    input  logic                            nRST,
    input  logic [REQ_COUNT-1:0]            REQ_VALID,
    input  logic [REQ_COUNT-1:0]            REQ_LAST,
    input  logic [REQ_COUNT*DATA_WIDTH-1:0] REQ_DATA,
    output logic [REQ_COUNT-1:0]            REQ_READY,
    output logic                            W_nEN,
    output logic [DATA_WIDTH-1:0]           W_DATA,
    input  logic                            W_FULL,
    output logic [ID_W(REQ_COUNT)-1:0]      GRANT_ID,
    output logic                            BUSY
);

    localparam int IW = ID_W(REQ_COUNT);
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t                           state;
    logic [IW-1:0]                        owner;
    logic [IW-1:0]                        last_id;
    logic [CW-1:0]                        beat_cnt;
    logic                                 found;
    logic [IW-1:0]                        win;
    logic                                 beat;
    logic                                 pkt_end;
    logic [REQ_COUNT-1:0][DATA_WIDTH-1:0] req_data_a;

    assign req_data_a = REQ_DATA;

    rr_pick #(
        .N  (REQ_COUNT),
        .IW (IW)
    ) u_pick (
        .req     (REQ_VALID),
        .last_id (last_id),
        .found   (found),
        .win     (win)
    );

    // Gating with nRST keeps a reset cycle from pushing a beat.
    always_comb begin
        beat             = nRST && (state == GRANT) && REQ_VALID[owner] && !W_FULL;
        REQ_READY        = '0;
        REQ_READY[owner] = beat;
        W_nEN            = !beat;
        W_DATA           = beat ? req_data_a[owner] : '0;
    end

    assign pkt_end  = REQ_LAST[owner] || (beat_cnt == CW'(MAX_BURST - 1));
    assign BUSY     = (state == GRANT);
    assign GRANT_ID = owner;

    always_ff @(posedge MCLK) begin
        if (!nRST) begin
            state    <= IDLE;
            owner    <= '0;
            last_id  <= IW'(REQ_COUNT - 1);
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        owner    <= win;
                        last_id  <= win;
                        beat_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (pkt_end) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Randomized scoreboard bench: a behavioural round-robin model predicts each
// cycle's outputs; a separate monitor pops and compares them.
module tb_fifo_push_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int MAXB = 8;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    typedef struct packed {
        logic            busy;
        logic [1:0]      gid;
        logic [NREQ-1:0] rdy;
        logic            wnen;
        logic [DW-1:0]   wdata;
    } exp_t;

    logic                 MCLK = 1'b0;
    logic                 nRST;
    logic [NREQ-1:0]      REQ_VALID;
    logic [NREQ-1:0]      REQ_LAST;
    logic [NREQ*DW-1:0]   REQ_DATA;
    logic [NREQ-1:0]      REQ_READY;
    logic                 W_nEN;
    logic [DW-1:0]        W_DATA;
    logic                 W_FULL;
    logic [1:0]           GRANT_ID;
    logic                 BUSY;

    fifo_push_arbiter #(
        .REQ_COUNT  (NREQ),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MAXB)
    ) dut (
        .MCLK      (MCLK),
        .nRST      (nRST),
        .REQ_VALID (REQ_VALID),
        .REQ_LAST  (REQ_LAST),
        .REQ_DATA  (REQ_DATA),
        .REQ_READY (REQ_READY),
        .W_nEN     (W_nEN),
        .W_DATA    (W_DATA),
        .W_FULL    (W_FULL),
        .GRANT_ID  (GRANT_ID),
        .BUSY      (BUSY)
    );

    always #5 MCLK = ~MCLK;

    beat_t req_q [NREQ][$];
    exp_t  exp_q [$];
    int    tests  = 0;
    int    fails  = 0;
    int    pushes = 0;
    bit    done   = 0;

    int refill_mode = 0;  // 0 none, 1 single-beat packets, 2 random lengths
    int bubble_pct  = 0;
    int full_pct    = 0;
    int rst_pct     = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic add_pkt(input int r, input int len);
        for (int b = 0; b < len; b++) begin
            beat_t bt;
            bt.d = $urandom;
            bt.l = (b == len - 1);
            req_q[r].push_back(bt);
        end
    endtask

    // Driver: new inputs shortly after each rising edge.
    task automatic drive_cycle();
        @(posedge MCLK);
        #1;
        nRST = ($urandom_range(99) >= rst_pct);
        W_FULL = ($urandom_range(99) < full_pct);
        for (int r = 0; r < NREQ; r++) begin
            if (req_q[r].size() == 0 && refill_mode == 1) add_pkt(r, 1);
            if (req_q[r].size() == 0 && refill_mode == 2 && $urandom_range(3) == 0)
                add_pkt(r, $urandom_range(20, 1));
            if (req_q[r].size() != 0) begin
                REQ_VALID[r] = ($urandom_range(99) >= bubble_pct);
                REQ_LAST[r]  = req_q[r][0].l;
                REQ_DATA[r*DW +: DW] = req_q[r][0].d;
            end else begin
                REQ_VALID[r] = 1'b0;
                REQ_LAST[r]  = 1'b0;
                REQ_DATA[r*DW +: DW] = '0;
            end
        end
    endtask

    initial begin
        nRST = 1'b0;
        REQ_VALID = '0;
        REQ_LAST = '0;
        REQ_DATA = '0;
        W_FULL = 1'b0;
        repeat (3) @(posedge MCLK);
        #1;
        nRST = 1'b1;
        // Single 3-beat packet on requester 2.
        for (int b = 0; b < 3; b++) begin
            beat_t bt;
            bt.d = 32'hA0 + b;
            bt.l = (b == 2);
            req_q[2].push_back(bt);
        end
        repeat (10) drive_cycle();
        // Round robin with single-beat packets.
        refill_mode = 1;
        repeat (40) drive_cycle();
        // Long packets hit the burst cap; the FIFO is full almost continuously.
        refill_mode = 2;
        full_pct = 85;
        repeat (300) drive_cycle();
        // Mixed traffic: bubbles, full stalls, occasional resets.
        bubble_pct = 20;
        full_pct = 20;
        rst_pct = 1;
        repeat (3000) drive_cycle();
        rst_pct = 0;
        repeat (3) @(posedge MCLK);
        done = 1;
        @(posedge MCLK);
        @(posedge MCLK);
        tests++;
        if (pushes < 100) begin
            fails++;
            $display("FAIL push_count: got %0d pushes expected at least 100", pushes);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Reference model: one entry per cycle, computed from the inputs the bench drove.
    int m_owner = -1;
    int m_last  = NREQ - 1;
    int m_cnt   = 0;

    initial begin
        while (!done) begin
            exp_t e;
            @(negedge MCLK);
            e.busy  = (m_owner >= 0);
            e.gid   = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
            e.rdy   = '0;
            e.wnen  = 1'b1;
            e.wdata = '0;
            if (!nRST) begin
                m_owner = -1;
                m_last  = NREQ - 1;
                m_cnt   = 0;
            end else if (m_owner < 0) begin
                for (int s = 1; s <= NREQ; s++) begin
                    int c;
                    c = (m_last + s) % NREQ;
                    if (m_owner < 0 && REQ_VALID[c]) begin
                        m_owner = c;
                        m_last  = c;
                        m_cnt   = 0;
                    end
                end
            end else if (REQ_VALID[m_owner] && !W_FULL) begin
                beat_t bt;
                bt = req_q[m_owner].pop_front();
                e.rdy[m_owner] = 1'b1;
                e.wnen  = 1'b0;
                e.wdata = bt.d;
                m_cnt++;
                if (bt.l || m_cnt == MAXB) m_owner = -1;
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: samples a moment after the falling edge, away from the active edge.
    initial begin
        while (!done) begin
            @(negedge MCLK);
            #1;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL scoreboard_empty @%0t: got no expectation expected one", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("busy", DW'(BUSY), DW'(e.busy));
                if (e.busy) chk("grant_id", DW'(GRANT_ID), DW'(e.gid));
                chk("req_ready", DW'(REQ_READY), DW'(e.rdy));
                chk("w_nen", DW'(W_nEN), DW'(e.wnen));
                chk("w_data", W_DATA, e.wdata);
                if (!W_nEN) pushes++;
            end
        end
    end

endmodule
